// File: rtl/mem_arbiter_if.sv
// Signal bundle for the three-master memory arbiter: per-master request/response
// lines plus the shared slave bus.
interface mem_arbiter_if;
    logic [63:0] m0_address_in,     m1_address_in,     m2_address_in;
    logic        m0_read_in,        m1_read_in,        m2_read_in;
    logic        m0_write_in,       m1_write_in,       m2_write_in;
    logic [3:0]  m0_write_mask_in,  m1_write_mask_in,  m2_write_mask_in;
    logic [63:0] m0_write_value_in, m1_write_value_in, m2_write_value_in;
    logic [63:0] m0_read_value_out, m1_read_value_out, m2_read_value_out;
    logic        m0_ready_out,      m1_ready_out,      m2_ready_out;
    logic        m0_error_out,      m1_error_out,      m2_error_out;

    logic [63:0] address_out;
    logic        read_out;
    logic        write_out;
    logic [3:0]  write_mask_out;
    logic [63:0] write_value_out;
    logic [63:0] read_value_in;
    logic        ready_in;

    // Arbiter view: it masters the shared bus and serves the requesters.
    modport master (
        input  m0_address_in, m1_address_in, m2_address_in,
        input  m0_read_in, m1_read_in, m2_read_in,
        input  m0_write_in, m1_write_in, m2_write_in,
        input  m0_write_mask_in, m1_write_mask_in, m2_write_mask_in,
        input  m0_write_value_in, m1_write_value_in, m2_write_value_in,
        output m0_read_value_out, m1_read_value_out, m2_read_value_out,
        output m0_ready_out, m1_ready_out, m2_ready_out,
        output m0_error_out, m1_error_out, m2_error_out,
        output address_out, read_out, write_out, write_mask_out, write_value_out,
        input  read_value_in, ready_in
    );

    // Environment view: requesters and the memory slave.
    modport slave (
        output m0_address_in, m1_address_in, m2_address_in,
        output m0_read_in, m1_read_in, m2_read_in,
        output m0_write_in, m1_write_in, m2_write_in,
        output m0_write_mask_in, m1_write_mask_in, m2_write_mask_in,
        output m0_write_value_in, m1_write_value_in, m2_write_value_in,
        input  m0_read_value_out, m1_read_value_out, m2_read_value_out,
        input  m0_ready_out, m1_ready_out, m2_ready_out,
        input  m0_error_out, m1_error_out, m2_error_out,
        input  address_out, read_out, write_out, write_mask_out, write_value_out,
        output read_value_in, ready_in
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory bus between instruction fetch (m0),
// data (m1) and DMA (m2), with a per-transaction wait timeout.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.master bus
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    state_t      state, next_state;

    logic [63:0] addr   [3];
    logic [3:0]  mask   [3];
    logic [63:0] wdata  [3];
    logic [2:0]  rd_req, wr_req, req;
    logic        req_any;
    logic [1:0]  pick;

    logic [1:0]  last_grant;
    logic [1:0]  grant_q;
    logic [63:0] addr_q, wdata_q;
    logic [3:0]  mask_q;
    logic        is_write_q;
    logic [15:0] wait_cnt;
    logic        err_q;
    logic [63:0] rd_val_q [3];
    logic        timeout_hit;

    assign addr   = '{bus.m0_address_in, bus.m1_address_in, bus.m2_address_in};
    assign mask   = '{bus.m0_write_mask_in, bus.m1_write_mask_in, bus.m2_write_mask_in};
    assign wdata  = '{bus.m0_write_value_in, bus.m1_write_value_in, bus.m2_write_value_in};
    assign rd_req = {bus.m2_read_in, bus.m1_read_in, bus.m0_read_in};
    assign wr_req = {bus.m2_write_in, bus.m1_write_in, bus.m0_write_in};
    assign req     = rd_req | wr_req;
    assign req_any = |req;

    assign timeout_hit = (wait_cnt == TIMEOUT_LAST);

    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    // Scan from the master after the last one served, wrapping modulo 3.
    always_comb begin
        logic [1:0] cand;
        logic       found;
        // NOTE: every variable written here gets a default first, so no path infers a latch.
        pick  = 2'd0;
        found = 1'b0;
        cand  = next_idx(last_grant);
        for (int k = 0; k < 3; k++) begin
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
            cand = next_idx(cand);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state          = state;
        bus.address_out     = '0;
        bus.read_out        = 1'b0;
        bus.write_out       = 1'b0;
        bus.write_mask_out  = '0;
        bus.write_value_out = '0;
        unique case (state)
            IDLE: if (req_any) next_state = BUSY;
            BUSY: begin
                bus.address_out     = addr_q;
                bus.read_out        = !is_write_q;
                bus.write_out       = is_write_q;
                bus.write_mask_out  = mask_q;
                bus.write_value_out = wdata_q;
                if (bus.ready_in || timeout_hit) next_state = RESP;
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 2'd2;
            grant_q    <= 2'd0;
            addr_q     <= '0;
            mask_q     <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            wait_cnt   <= '0;
            err_q      <= 1'b0;
            // NOTE: this small register array is reset explicitly because its contents are visible outputs.
            for (int i = 0; i < 3; i++) rd_val_q[i] <= '0;
        end else begin
            unique case (state)
                IDLE: if (req_any) begin
                    grant_q    <= pick;
                    addr_q     <= addr[pick];
                    mask_q     <= mask[pick];
                    wdata_q    <= wdata[pick];
                    is_write_q <= wr_req[pick];
                    wait_cnt   <= '0;
                    err_q      <= 1'b0;
                end
                BUSY: begin
                    if (bus.ready_in) begin
                        if (!is_write_q) rd_val_q[grant_q] <= bus.read_value_in;
                    end else if (timeout_hit) begin
                        err_q             <= 1'b1;
                        rd_val_q[grant_q] <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                RESP:    last_grant <= grant_q;
                default: ;
            endcase
        end
    end

    assign bus.m0_read_value_out = rd_val_q[0];
    assign bus.m1_read_value_out = rd_val_q[1];
    assign bus.m2_read_value_out = rd_val_q[2];

    assign bus.m0_ready_out = (state == RESP) && (grant_q == 2'd0);
    assign bus.m1_ready_out = (state == RESP) && (grant_q == 2'd1);
    assign bus.m2_ready_out = (state == RESP) && (grant_q == 2'd2);
    assign bus.m0_error_out = bus.m0_ready_out && err_q;
    assign bus.m1_error_out = bus.m1_ready_out && err_q;
    assign bus.m2_error_out = bus.m2_ready_out && err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT=4): a per-cycle vector table for
// round-robin reads, then hand-written sequences for the multi-cycle cases.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    mem_arbiter_if bus ();

    mem_arbiter #(.TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [2:0]  rd;
        logic [2:0]  wr;
        logic        rdy_in;
        logic [63:0] rdata;
        logic        exp_rd;
        logic        exp_wr;
        logic [63:0] exp_addr;
        logic [2:0]  exp_ready;
        logic [2:0]  exp_error;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [2:0] rd, input logic [2:0] wr);
        bus.m0_read_in  = rd[0]; bus.m1_read_in  = rd[1]; bus.m2_read_in  = rd[2];
        bus.m0_write_in = wr[0]; bus.m1_write_in = wr[1]; bus.m2_write_in = wr[2];
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_req(3'b000, 3'b000);
        bus.ready_in = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [2:0] readies();
        return {bus.m2_ready_out, bus.m1_ready_out, bus.m0_ready_out};
    endfunction

    function automatic logic [2:0] errs();
        return {bus.m2_error_out, bus.m1_error_out, bus.m0_error_out};
    endfunction

    initial begin
        int busy_cycles;
        int rd_cycles;
        logic seen;

        reset = 1'b1;
        set_req(3'b000, 3'b000);
        bus.m0_address_in = 64'h100; bus.m1_address_in = 64'h200; bus.m2_address_in = 64'h300;
        bus.m0_write_mask_in = 4'hF; bus.m1_write_mask_in = 4'h3; bus.m2_write_mask_in = 4'h0;
        bus.m0_write_value_in = 64'h1111; bus.m1_write_value_in = 64'h1234;
        bus.m2_write_value_in = 64'h2222;
        bus.ready_in = 1'b0;
        bus.read_value_in = '0;

        // All three masters read continuously with the slave always ready.
        tbl[0]  = '{1'b1, 3'b000, 3'b000, 1'b0, 64'h0,  1'b0, 1'b0, 64'h0,   3'b000, 3'b000};
        tbl[1]  = '{1'b0, 3'b111, 3'b000, 1'b1, 64'h0,  1'b1, 1'b0, 64'h100, 3'b000, 3'b000};
        tbl[2]  = '{1'b0, 3'b111, 3'b000, 1'b1, 64'hA0, 1'b0, 1'b0, 64'h0,   3'b001, 3'b000};
        tbl[3]  = '{1'b0, 3'b111, 3'b000, 1'b1, 64'h0,  1'b0, 1'b0, 64'h0,   3'b000, 3'b000};
        tbl[4]  = '{1'b0, 3'b111, 3'b000, 1'b1, 64'h0,  1'b1, 1'b0, 64'h200, 3'b000, 3'b000};
        tbl[5]  = '{1'b0, 3'b111, 3'b000, 1'b1, 64'hA1, 1'b0, 1'b0, 64'h0,   3'b010, 3'b000};
        tbl[6]  = '{1'b0, 3'b111, 3'b000, 1'b1, 64'h0,  1'b0, 1'b0, 64'h0,   3'b000, 3'b000};
        tbl[7]  = '{1'b0, 3'b111, 3'b000, 1'b1, 64'h0,  1'b1, 1'b0, 64'h300, 3'b000, 3'b000};
        tbl[8]  = '{1'b0, 3'b111, 3'b000, 1'b1, 64'hA2, 1'b0, 1'b0, 64'h0,   3'b100, 3'b000};
        tbl[9]  = '{1'b0, 3'b111, 3'b000, 1'b1, 64'h0,  1'b0, 1'b0, 64'h0,   3'b000, 3'b000};
        tbl[10] = '{1'b0, 3'b111, 3'b000, 1'b1, 64'h0,  1'b1, 1'b0, 64'h100, 3'b000, 3'b000};
        tbl[11] = '{1'b0, 3'b111, 3'b000, 1'b1, 64'hA3, 1'b0, 1'b0, 64'h0,   3'b001, 3'b000};
        tbl[12] = '{1'b0, 3'b000, 3'b000, 1'b0, 64'h0,  1'b0, 1'b0, 64'h0,   3'b000, 3'b000};

        for (int i = 0; i < 13; i++) begin
            reset = tbl[i].rst;
            set_req(tbl[i].rd, tbl[i].wr);
            bus.ready_in      = tbl[i].rdy_in;
            bus.read_value_in = tbl[i].rdata;
            tick();
            check($sformatf("vec%0d read_out", i),    64'(bus.read_out),    64'(tbl[i].exp_rd));
            check($sformatf("vec%0d write_out", i),   64'(bus.write_out),   64'(tbl[i].exp_wr));
            check($sformatf("vec%0d address_out", i), bus.address_out,      tbl[i].exp_addr);
            check($sformatf("vec%0d ready", i),       64'(readies()),       64'(tbl[i].exp_ready));
            check($sformatf("vec%0d error", i),       64'(errs()),          64'(tbl[i].exp_error));
            if (!tbl[i].exp_rd && !tbl[i].exp_wr) begin
                check($sformatf("vec%0d mask idle", i),  64'(bus.write_mask_out), 64'h0);
                check($sformatf("vec%0d value idle", i), bus.write_value_out,     64'h0);
            end
        end
        check("rr m0 read value", bus.m0_read_value_out, 64'hA3);
        check("rr m1 read value", bus.m1_read_value_out, 64'hA1);
        check("rr m2 read value", bus.m2_read_value_out, 64'hA2);

        // Single m0 read, slave ready on the second bus cycle.
        do_reset();
        check("reset m0 value", bus.m0_read_value_out, 64'h0);
        check("reset ready", 64'(readies()), 64'h0);
        rd_cycles = 0;
        set_req(3'b001, 3'b000);
        tick();
        rd_cycles += int'(bus.read_out);
        check("single addr", bus.address_out, 64'h100);
        tick();
        rd_cycles += int'(bus.read_out);
        bus.ready_in = 1'b1;
        bus.read_value_in = 64'hDEADBEEF;
        tick();
        rd_cycles += int'(bus.read_out);
        check("single ready pulse", 64'(readies()), 64'b001);
        check("single value", bus.m0_read_value_out, 64'hDEADBEEF);
        set_req(3'b000, 3'b000);
        bus.ready_in = 1'b0;
        tick();
        rd_cycles += int'(bus.read_out);
        check("single read cycles", 64'(rd_cycles), 64'd2);
        check("single ready drop", 64'(readies()), 64'h0);
        check("single value hold", bus.m0_read_value_out, 64'hDEADBEEF);

        // m1 read, then read+write request becomes a write; then m2 write with empty mask.
        do_reset();
        set_req(3'b010, 3'b000);
        bus.ready_in = 1'b1;
        bus.read_value_in = 64'hAAAA;
        tick();
        tick();
        check("m1 first read", bus.m1_read_value_out, 64'hAAAA);
        set_req(3'b000, 3'b000);
        tick();
        set_req(3'b010, 3'b010);
        bus.read_value_in = 64'hFFFF;
        tick();
        check("rw write_out", 64'(bus.write_out), 64'd1);
        check("rw read_out", 64'(bus.read_out), 64'd0);
        check("rw mask", 64'(bus.write_mask_out), 64'h3);
        check("rw value", bus.write_value_out, 64'h1234);
        check("rw addr", bus.address_out, 64'h200);
        tick();
        check("rw ready", 64'(readies()), 64'b010);
        check("rw value unchanged", bus.m1_read_value_out, 64'hAAAA);
        set_req(3'b000, 3'b100);
        tick();
        tick();
        check("mask0 write_out", 64'(bus.write_out), 64'd1);
        check("mask0 mask", 64'(bus.write_mask_out), 64'h0);
        check("mask0 addr", bus.address_out, 64'h300);
        tick();
        check("mask0 ready", 64'(readies()), 64'b100);
        set_req(3'b000, 3'b000);
        tick();

        // m2 timeout: a good read first, then a read the slave never answers.
        do_reset();
        set_req(3'b100, 3'b000);
        bus.ready_in = 1'b1;
        bus.read_value_in = 64'h55;
        tick();
        tick();
        check("to prior error", 64'(errs()), 64'h0);
        check("to prior value", bus.m2_read_value_out, 64'h55);
        set_req(3'b000, 3'b000);
        bus.ready_in = 1'b0;
        tick();
        set_req(3'b100, 3'b000);
        busy_cycles = 0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            busy_cycles += int'(bus.read_out);
            if (bus.m2_ready_out) seen = 1'b1;
        end
        check("to ready seen", 64'(seen), 64'd1);
        check("to busy cycles", 64'(busy_cycles), 64'd4);
        check("to error", 64'(errs()), 64'b100);
        check("to value zero", bus.m2_read_value_out, 64'h0);
        set_req(3'b000, 3'b000);
        tick();
        check("to error drop", 64'(errs()), 64'h0);

        // Reset on the second bus cycle of an m0 read, after m0 was last served.
        do_reset();
        set_req(3'b001, 3'b000);
        bus.ready_in = 1'b1;
        tick();
        tick();
        set_req(3'b000, 3'b000);
        bus.ready_in = 1'b0;
        tick();
        set_req(3'b001, 3'b000);
        tick();
        tick();
        check("abort busy", 64'(bus.read_out), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort read_out", 64'(bus.read_out), 64'd0);
        check("abort addr", bus.address_out, 64'h0);
        check("abort ready", 64'(readies()), 64'h0);
        check("abort value", bus.m0_read_value_out, 64'h0);
        set_req(3'b011, 3'b000);
        tick();
        check("abort regrant m0", bus.address_out, 64'h100);
        bus.ready_in = 1'b1;
        tick();
        check("abort regrant ready", 64'(readies()), 64'b001);
        set_req(3'b000, 3'b000);
        bus.ready_in = 1'b0;
        tick();

        // Address change during the bus phase is ignored.
        do_reset();
        set_req(3'b001, 3'b000);
        tick();
        bus.m0_address_in = 64'hBAD;
        tick();
        check("hold addr", bus.address_out, 64'h100);
        bus.ready_in = 1'b1;
        tick();
        check("hold ready", 64'(readies()), 64'b001);
        set_req(3'b000, 3'b000);
        bus.ready_in = 1'b0;
        bus.m0_address_in = 64'h100;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
